// File: rtl/mod_mul_arb.sv
// Round-robin arbiter sharing one combinational mod_mul between N_REQ requesters.
// Optional MOD_MUL_ARB_RANGE_CHECK_EN adds rsp_err_o for out-of-range operands.

module mod_mul #(
   parameter int DATA_W = 23
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              select_i,
   output logic [DATA_W-1:0] c_o
);
   localparam logic [2*DATA_W-1:0] Q_KYBER     = (2*DATA_W)'(3329);
   localparam logic [2*DATA_W-1:0] Q_DILITHIUM = (2*DATA_W)'(8380417);

   logic [2*DATA_W-1:0] prod;

   always_comb begin
      prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
      c_o  = DATA_W'(select_i ? (prod % Q_KYBER) : (prod % Q_DILITHIUM));
   end
endmodule

// state | meaning
// IDLE  | arbitrate; grant and latch one request
// CALC  | mod_mul evaluates latched operands; result captured
// RESP  | result presented until rsp_ready_i
module mod_mul_arb #(
   parameter int N_REQ  = 4,
   parameter int ID_W   = $clog2(N_REQ),
   parameter int DATA_W = 23
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   output logic [N_REQ-1:0]         req_ready_o,
   input  logic [N_REQ*DATA_W-1:0]  req_a_i,
   input  logic [N_REQ*DATA_W-1:0]  req_b_i,
   input  logic [N_REQ-1:0]         req_select_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_W-1:0]        rsp_c_o,
   output logic [ID_W-1:0]          rsp_id_o,
`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
   output logic                     rsp_err_o,
`endif
   output logic                     busy_o
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     gnt_id;
   logic                gnt_found;
   logic [DATA_W-1:0]   op_a, op_b;
   logic                op_sel;
   logic [ID_W-1:0]     op_id;
   logic [DATA_W-1:0]   res_c;
   logic [DATA_W-1:0]   mul_c;

   mod_mul #(.DATA_W(DATA_W)) u_mod_mul (
      .a_i      (op_a),
      .b_i      (op_b),
      .select_i (op_sel),
      .c_o      (mul_c)
   );

`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
   localparam logic [DATA_W-1:0] Q_KYBER     = DATA_W'(3329);
   localparam logic [DATA_W-1:0] Q_DILITHIUM = DATA_W'(8380417);

   logic res_err;
   logic range_err;

   always_comb begin
      range_err = op_sel ? ((op_a >= Q_KYBER) || (op_b >= Q_KYBER))
                         : ((op_a >= Q_DILITHIUM) || (op_b >= Q_DILITHIUM));
   end

   assign rsp_err_o = res_err;
`endif

   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!gnt_found && req_valid_i[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
   end

   // ready is also masked by rst_n_i so nothing is accepted while reset is held
   always_comb begin
      state_nxt   = state;
      req_ready_o = '0;
      case (state)
         IDLE: begin
            if (gnt_found && rst_n_i) begin
               req_ready_o[gnt_id] = 1'b1;
               state_nxt           = CALC;
            end
         end
         CALC:    state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= IDLE;
         rr_ptr <= '0;
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= 1'b0;
         op_id  <= '0;
         res_c  <= '0;
`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
         res_err <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && gnt_found) begin
            op_a   <= req_a_i[gnt_id*DATA_W +: DATA_W];
            op_b   <= req_b_i[gnt_id*DATA_W +: DATA_W];
            op_sel <= req_select_i[gnt_id];
            op_id  <= gnt_id;
            rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
         end
         if (state == CALC) begin
`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
            res_c   <= range_err ? '0 : mul_c;
            res_err <= range_err;
`else
            res_c <= mul_c;
`endif
         end
      end
   end

   assign rsp_valid_o = (state == RESP);
   assign rsp_c_o     = res_c;
   assign rsp_id_o    = op_id;
   assign busy_o      = (state != IDLE);
endmodule

// File: tb/tb_mod_mul_arb.sv
// Scoreboard bench for mod_mul_arb: directed requests, monitor checks each response handshake.
module tb_mod_mul_arb;
   localparam int N    = 4;
   localparam int IW   = 2;
   localparam int DW   = 23;
`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] c;
      logic          err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [N*DW-1:0]  req_a = '0;
   logic [N*DW-1:0]  req_b = '0;
   logic [N-1:0]     req_sel = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [DW-1:0]    rsp_c;
   logic [IW-1:0]    rsp_id;
   logic             rsp_err;
   logic             busy;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   gnt_cyc = 0;

   mod_mul_arb #(.N_REQ(N), .ID_W(IW), .DATA_W(DW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_select_i (req_sel),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_c_o      (rsp_c),
      .rsp_id_o     (rsp_id),
`ifdef MOD_MUL_ARB_RANGE_CHECK_EN
      .rsp_err_o    (rsp_err),
`endif
      .busy_o       (busy)
   );
`ifndef MOD_MUL_ARB_RANGE_CHECK_EN
   assign rsp_err = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int k, input logic v, input logic s,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_valid[k]         = v;
      req_sel[k]           = s;
      req_a[k*DW +: DW]    = a;
      req_b[k*DW +: DW]    = b;
   endtask

   // Call at a falling edge; returns at falling edge + 1 of the grant cycle.
   task automatic wait_grant(input int k, input logic [DW-1:0] c, input logic e, input bit push);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         #1;
         if (req_ready != '0) begin
            got = 1'b1;
            chk("grant", req_ready, 32'(1) << k);
            gnt_cyc = cyc;
            if (push) sb.push_back('{id: IW'(k), c: c, err: e});
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: got no ready expected requester %0d", k);
      end
   endtask

   // Response monitor: samples just before the rising edge that completes a handshake.
   always begin
      exp_t e;
      @(negedge clk);
      #4;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d c %0h expected none", rsp_id, rsp_c);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_c", rsp_c, e.c);
            if (RC) chk("rsp_err", rsp_err, e.err);
         end
      end
   end

   logic [DW-1:0] rr_a [4] = '{23'h2, 23'h7B6, 23'd1000, 23'd100};
   logic [DW-1:0] rr_b [4] = '{23'h3, 23'hC92, 23'd1000, 23'd100};
   logic          rr_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [DW-1:0] rr_c [4] = '{23'd6, 23'h258, 23'd1000000, 23'd13};

   initial begin
      int prev;
      int order [5] = '{0, 1, 2, 3, 0};

      // reset values, including ready masked while valid is high in reset
      req_valid[0] = 1'b1;
      #12;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_c", rsp_c, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      if (RC) chk("rst_err", rsp_err, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // single request, latency check
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 23'h0B7, 23'hABC);
      wait_grant(0, 23'h0CD, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1 chk("lat_t1_valid", rsp_valid, 0);
      @(negedge clk);
      #1 chk("lat_t2_valid", rsp_valid, 1);
      repeat (3) @(negedge clk);

      // large modulus under backpressure; rr_ptr=1 so req 2 wins over req 0
      rsp_ready = 1'b0;
      set_req(0, 1'b1, 1'b1, 23'h2, 23'h3);
      set_req(2, 1'b1, 1'b0, 23'h57882B, 23'h7F0FEA);
      wait_grant(2, 23'h324294, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_c", rsp_c, 23'h324294);
         chk("bp_id", rsp_id, 2);
         chk("bp_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1 chk("bp_idle", busy, 0);
      wait_grant(0, 23'd6, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);

      // round-robin from fresh reset
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) set_req(k, 1'b1, rr_s[k], rr_a[k], rr_b[k]);
      prev = 0;
      for (int g = 0; g < 5; g++) begin
         wait_grant(order[g], rr_c[order[g]], 1'b0, 1'b1);
         if (g > 0) chk("rr_gap", gnt_cyc - prev, 3);
         prev = gnt_cyc;
         @(posedge clk);
         @(negedge clk);
      end
      req_valid = '0;
      repeat (4) @(negedge clk);

      // reset while CALC: response discarded
      set_req(1, 1'b1, 1'b0, 23'h4625CA, 23'h7F822C);
      wait_grant(1, 23'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid", rsp_valid, 0);
      chk("mid_c", rsp_c, 0);
      chk("mid_id", rsp_id, 0);
      chk("mid_busy", busy, 0);
      chk("mid_ready", req_ready, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("mid_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      set_req(1, 1'b1, 1'b0, 23'h4625CA, 23'h7F822C);
      set_req(3, 1'b1, 1'b1, 23'h2, 23'h3);
      wait_grant(1, 23'h792068, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      wait_grant(3, 23'd6, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);

      // out-of-range kyber operand
      set_req(3, 1'b1, 1'b1, 23'hEA1, 23'h6C6);
      wait_grant(3, RC ? 23'h0 : 23'h8E8, RC, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mod_mul_arb.md
Name: mod_mul_arb

Overview:
- Round-robin arbiter and sequencer sharing one combinational mod_mul instance between N_REQ requesters (NTT butterfly lanes, pointwise-multiply engine, key-gen sampler).
- Each requester issues (a, b, select) over a valid/ready channel.
- The block grants one requester, registers its operands, registers the mod_mul result, and returns it tagged with the requester index over one shared response channel.
- Exactly one operation is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters, legal range 2..8.
- ID_W, $clog2(N_REQ), width of the requester index.
- DATA_W, 23, operand/result width; must match mod_mul.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  N_REQ*DATA_W  packed operand a; requester k at [k*DATA_W +: DATA_W].
- req_b_i  in  N_REQ*DATA_W  packed operand b, same packing.
- req_select_i  in  N_REQ  per-requester modulus select: 1 = q 3329 (12-bit operands in low bits), 0 = q 8380417.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_c_o  out  DATA_W  a*b mod q.
- rsp_id_o  out  ID_W  index of the requester that owns rsp_c_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, rr_ptr=0, operand/select/id/result registers cleared.
  - req_ready_o=0, rsp_valid_o=0, rsp_c_o=0, rsp_id_o=0, busy_o=0.
  - An in-flight operation is discarded and no response is produced.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - req_ready_o[g]=1 combinationally in that same cycle; handshake completes on that edge.
  - On the edge: latch a, b, select and g; rr_ptr<=(g+1) mod N_REQ; state<=CALC.
  - No valid: stay in IDLE, req_ready_o=0.
- CALC:
  - mod_mul is fed from the operand registers; its output is captured into the result register on the edge.
  - state<=RESP. req_ready_o=0.
- RESP:
  - rsp_valid_o=1. rsp_c_o and rsp_id_o are stable until the handshake.
  - If rsp_ready_i=1, state<=IDLE on the edge; otherwise hold indefinitely.
  - req_ready_o=0 throughout.
- Latency and throughput:
  - Request handshake in cycle t gives rsp_valid_o high from cycle t+2.
  - With rsp_ready_i held at 1, maximum throughput is one operation per 3 cycles.
  - A new grant is possible in the cycle after the response handshake.
- req_ready_o is never asserted for a requester whose valid is low, and is never asserted outside IDLE.
- Requesters must hold valid and operands stable until ready; a valid dropped before grant is simply not served.
- Fairness: a requester holding valid continuously is granted within N_REQ grants.
- Wrap-around: granting index N_REQ-1 sets rr_ptr to 0.
- Arithmetic is entirely mod_mul's. The arbiter neither reduces nor truncates operands; with select=1 it passes all DATA_W bits unchanged.

Optional Feature:
- Macro: MOD_MUL_ARB_RANGE_CHECK_EN.
- Defined:
  - Adds output rsp_err_o (1 bit), reset 0 and valid together with rsp_valid_o.
  - In CALC, if a>=q or b>=q for the latched select (select=1 also flags any nonzero bit above bit 11), rsp_err_o=1 and rsp_c_o=0.
  - Otherwise rsp_err_o=0.
- Not defined: the port is absent and operands pass to mod_mul unchecked.

Test Plan:
- Single request: req 0, select=1, a=0x0B7, b=0xABC; ready pulses in the same cycle; 2 cycles later rsp_valid_o=1, rsp_c_o=0x0CD, rsp_id_o=0.
- Large modulus: req 2, select=0, a=0x57882B, b=0x7F0FEA -> rsp_c_o=0x324294, rsp_id_o=2.
- Round-robin:
  - All 4 valid from reset, rsp_ready_i=1 -> grant order 0,1,2,3,0.
  - Responses 3 cycles apart.
  - Req 1 operands a=0x7B6, b=0xC92, select=1 -> 0x258.
- Backpressure: rsp_ready_i=0 for 10 cycles in RESP -> rsp_valid_o, rsp_c_o and rsp_id_o stay constant, req_ready_o=0, no new grant; release -> IDLE the next cycle.
- Reset mid-op: assert rst_n_i low in CALC holding a=0x4625CA, b=0x7F822C -> all outputs 0 immediately; after release no response appears; the same request resubmitted -> 0x792068, and with rr_ptr reset the lowest valid index is served first.
- With MOD_MUL_ARB_RANGE_CHECK_EN: select=1, a=0xEA1, b=0x6C6 -> rsp_err_o=1, rsp_c_o=0. Without the macro: same stimulus -> rsp_c_o=0x8E8.
